// File: rtl/frame_rx_if.sv
// frame_rx bus bundle: strobed input words and the body-word
// ready/valid output stream.
interface frame_rx_if #(
  parameter int W = 8
);
  logic         bus_valid;
  logic [W-1:0] bus_data;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_ready;

  modport master (
    output bus_valid,
    output bus_data,
    output m_ready,
    input  m_valid,
    input  m_data,
    input  m_last
  );

  modport slave (
    input  bus_valid,
    input  bus_data,
    input  m_ready,
    output m_valid,
    output m_data,
    output m_last
  );
endinterface

// File: rtl/frame_rx.sv
// frame_rx: parses head/body/tail frames, queues body words,
// checks XOR checksum, aborts stalled frames, flags stray words.
module frame_rx #(
  parameter int       W        = 8,
  parameter logic [3:0] HEAD_TAG = 4'hA,
  parameter int       DEPTH    = 4,
  parameter int       TIMEOUT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  frame_rx_if.slave  bus,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [1:0] err_code,
  output logic       hdr_err
);

  localparam int LW = W - 4;
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    TAIL
  } state_t;

  state_t        state;
  logic [LW-1:0] cnt;
  logic [W-1:0]  xacc;
  logic [GW-1:0] gap;
  logic          ovf;

  logic [W:0]    mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;

  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          push_ok;
  logic          last_w;
  logic [3:0]    tag;
  logic [LW-1:0] len;
  logic          head_ok;
  logic [1:0]    tail_err;

  assign tag     = bus.bus_data[W-1:W-4];
  assign len     = bus.bus_data[W-5:0];
  assign head_ok = (tag == HEAD_TAG) && (len != '0);

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                 (wptr[AW] != rptr[AW]);
  assign pop   = ~empty & bus.m_ready;

  assign push    = (state == BODY) & bus.bus_valid;
  assign push_ok = push & (~full | pop);
  assign last_w  = (cnt == LW'(1));

  always_comb begin
    tail_err = 2'd0;
    if (ovf)
      tail_err = 2'd2;
    else if (bus.bus_data != xacc)
      tail_err = 2'd1;
  end

  // Output word is read straight from the queue head; gated to 0 when empty.
  assign bus.m_valid = ~empty;
  assign bus.m_data  = empty ? '0 : mem[rptr[AW-1:0]][W-1:0];
  assign bus.m_last  = empty ? 1'b0 : mem[rptr[AW-1:0]][W];

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wptr[AW-1:0]] <= {last_w, bus.bus_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      xacc       <= '0;
      gap        <= '0;
      ovf        <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= 2'd0;
      hdr_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= 2'd0;
      hdr_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          gap <= '0;
          if (bus.bus_valid) begin
            if (head_ok) begin
              cnt   <= len;
              xacc  <= '0;
              ovf   <= 1'b0;
              state <= BODY;
            end else begin
              hdr_err <= 1'b1;
            end
          end
        end
        BODY, TAIL: begin
          if (bus.bus_valid) begin
            gap <= '0;
            if (state == BODY) begin
              xacc <= xacc ^ bus.bus_data;
              cnt  <= cnt - 1'b1;
              if (push & ~push_ok)
                ovf <= 1'b1;
              if (last_w)
                state <= TAIL;
            end else begin
              frame_done <= 1'b1;
              frame_ok   <= (tail_err == 2'd0);
              err_code   <= tail_err;
              state      <= IDLE;
            end
          end else if (gap == GW'(TIMEOUT - 1)) begin
            // Abort lands on the TIMEOUT-th consecutive idle edge.
            gap        <= '0;
            frame_done <= 1'b1;
            err_code   <= 2'd3;
            state      <= IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_rx.sv
// Directed bench for frame_rx: frames, checksum, overflow,
// timeout, stray words and mid-frame reset.
module tb_frame_rx;

  logic       clk;
  logic       rst;
  logic       frame_done;
  logic       frame_ok;
  logic [1:0] err_code;
  logic       hdr_err;

  int nvec;
  int nerr;
  int ndone;

  logic [7:0] got_d [$];
  logic       got_l [$];

  frame_rx_if #(.W(8)) bus ();

  frame_rx #(
    .W(8),
    .HEAD_TAG(4'hA),
    .DEPTH(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .frame_done(frame_done),
    .frame_ok(frame_ok),
    .err_code(err_code),
    .hdr_err(hdr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record pops and done pulses mid-cycle, between active edges.
  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      got_d.push_back(bus.m_data);
      got_l.push_back(bus.m_last);
    end
    if (frame_done)
      ndone++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    bus.bus_valid = v;
    bus.bus_data  = d;
    @(posedge clk);
    #1;
    bus.bus_valid = 1'b0;
    bus.bus_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 8'h00);
  endtask

  task automatic chk_end(input string tag,
                         input logic ok,
                         input logic [1:0] ec);
    chk({tag, "_done"}, 32'(frame_done), 32'd1);
    chk({tag, "_ok"}, 32'(frame_ok), 32'(ok));
    chk({tag, "_err"}, 32'(err_code), 32'(ec));
  endtask

  task automatic chk_words(input string tag,
                           input logic [7:0] d [],
                           input logic l []);
    chk({tag, "_nw"}, 32'(got_d.size()), 32'(d.size()));
    for (int i = 0; i < d.size(); i++) begin
      if (i < got_d.size()) begin
        chk($sformatf("%s_d%0d", tag, i), 32'(got_d[i]), 32'(d[i]));
        chk($sformatf("%s_l%0d", tag, i), 32'(got_l[i]), 32'(l[i]));
      end
    end
    got_d.delete();
    got_l.delete();
  endtask

  initial begin
    int d0;
    nvec = 0;
    nerr = 0;
    ndone = 0;
    rst = 1'b1;
    bus.bus_valid = 1'b0;
    bus.bus_data  = 8'h00;
    bus.m_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mvalid", 32'(bus.m_valid), 32'd0);
    chk("rst_mdata", 32'(bus.m_data), 32'd0);
    chk("rst_mlast", 32'(bus.m_last), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ok", 32'(frame_ok), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_hdr", 32'(hdr_err), 32'd0);
    rst = 1'b0;
    idle(2);

    // basic frame
    cyc(1, 8'hA3); cyc(1, 8'h11); cyc(1, 8'h22); cyc(1, 8'h44);
    cyc(1, 8'h77);
    chk_end("basic", 1'b1, 2'd0);
    idle(1);
    chk("basic_pulse", 32'(frame_done), 32'd0);
    chk("basic_okz", 32'(frame_ok), 32'd0);
    idle(3);
    chk_words("basic", '{8'h11, 8'h22, 8'h44}, '{1'b0, 1'b0, 1'b1});

    // bad checksum
    cyc(1, 8'hA3); cyc(1, 8'h11); cyc(1, 8'h22); cyc(1, 8'h44);
    cyc(1, 8'h76);
    chk_end("badck", 1'b0, 2'd1);
    idle(4);
    chk_words("badck", '{8'h11, 8'h22, 8'h44}, '{1'b0, 1'b0, 1'b1});

    // overflow
    bus.m_ready = 1'b0;
    cyc(1, 8'hA6);
    for (int i = 1; i <= 6; i++)
      cyc(1, 8'(i));
    cyc(1, 8'h07);
    chk_end("ovf", 1'b0, 2'd2);
    chk("ovf_mvalid", 32'(bus.m_valid), 32'd1);
    chk("ovf_head", 32'(bus.m_data), 32'h01);
    chk("ovf_nopop", 32'(got_d.size()), 32'd0);
    bus.m_ready = 1'b1;
    idle(8);
    chk_words("ovf", '{8'h01, 8'h02, 8'h03, 8'h04},
              '{1'b0, 1'b0, 1'b0, 1'b0});

    // timeout
    cyc(1, 8'hA2); cyc(1, 8'h01);
    idle(7);
    chk("to_early", 32'(frame_done), 32'd0);
    idle(1);
    chk_end("to", 1'b0, 2'd3);
    cyc(1, 8'hA1); cyc(1, 8'h5A); cyc(1, 8'h5A);
    chk_end("after_to", 1'b1, 2'd0);
    idle(3);
    chk_words("to", '{8'h01, 8'h5A}, '{1'b0, 1'b1});

    // 7-cycle gaps between every word
    d0 = ndone;
    cyc(1, 8'hA2); idle(7);
    cyc(1, 8'h10); idle(7);
    cyc(1, 8'h20); idle(7);
    cyc(1, 8'h30);
    chk_end("gaps", 1'b1, 2'd0);
    idle(2);
    chk("gaps_ndone", 32'(ndone - d0), 32'd1);
    chk_words("gaps", '{8'h10, 8'h20}, '{1'b0, 1'b1});

    // stray words in IDLE
    cyc(1, 8'h53);
    chk("stray1", 32'(hdr_err), 32'd1);
    cyc(1, 8'hA0);
    chk("stray2", 32'(hdr_err), 32'd1);
    idle(1);
    chk("stray_clr", 32'(hdr_err), 32'd0);
    idle(2);
    chk("stray_nopush", 32'(got_d.size()), 32'd0);
    cyc(1, 8'hA1); cyc(1, 8'h3C); cyc(1, 8'h3C);
    chk_end("stray_next", 1'b1, 2'd0);
    idle(3);
    chk_words("stray", '{8'h3C}, '{1'b1});

    // reset mid-frame
    d0 = ndone;
    bus.m_ready = 1'b0;
    cyc(1, 8'hA3); cyc(1, 8'h11); cyc(1, 8'h22);
    rst = 1'b1;
    #1;
    chk("mrst_mvalid", 32'(bus.m_valid), 32'd0);
    chk("mrst_mdata", 32'(bus.m_data), 32'd0);
    chk("mrst_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    idle(2);
    chk("mrst_ndone", 32'(ndone - d0), 32'd0);
    chk("mrst_empty", 32'(got_d.size()), 32'd0);
    cyc(1, 8'hA1); cyc(1, 8'h33); cyc(1, 8'h33);
    chk_end("mrst_next", 1'b1, 2'd0);
    idle(3);
    chk_words("mrst", '{8'h33}, '{1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
